// File: rtl/wishbone_pkg.sv
// Shared definitions for the Wishbone command master and the register-file slave side.
// State encoding, default bus widths and the debug error-counter width live here.
package wishbone_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_ADR_W = 4;
   localparam int DEF_DAT_W = 32;
   localparam int ERR_CNT_W = 8;
   localparam int TMO_CNT_W = 8;

   // Debug counters stick at all-ones rather than wrapping back to zero.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
   endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog: counts enabled cycles from a clear and flags the last allowed cycle.
// expire_o is high while the count equals TIMEOUT-1.
module wb_timeout_counter
   import wishbone_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   logic [TMO_CNT_W-1:0] cnt_q;
   logic [TMO_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + TMO_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == TMO_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wishbone_cmd_master.sv
// Single-outstanding Wishbone classic master: one command in, one bus cycle, one response out.
// Bus cycles are bounded by a timeout; timeouts are counted in a saturating debug counter.
module wishbone_cmd_master
   import wishbone_pkg::*;
#(
   parameter int ADR_W   = DEF_ADR_W,
   parameter int DAT_W   = DEF_DAT_W,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_we,
   input  logic [ADR_W-1:0]     cmd_adr,
   input  logic [DAT_W-1:0]     cmd_dat,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DAT_W-1:0]     rsp_dat,
   output logic                 rsp_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [ADR_W-1:0]     wb_adr,
   output logic [DAT_W-1:0]     wb_dat_mosi,
   input  logic [DAT_W-1:0]     wb_dat_miso,
   output logic                 wb_we,
   output logic                 wb_cyc,
   output logic                 wb_stb,
   input  logic                 wb_ack
);

   state_t               state_q;
   logic                 rsp_valid_q;
   logic [DAT_W-1:0]     rsp_dat_q;
   logic                 rsp_err_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic [ERR_CNT_W-1:0] err_cnt_d;
   logic [ADR_W-1:0]     wb_adr_q;
   logic [DAT_W-1:0]     wb_dat_mosi_q;
   logic                 wb_we_q;
   logic                 wb_cyc_q;
   logic                 wb_stb_q;

   logic tmo_clr;
   logic tmo_en;
   logic tmo_expire;

   assign tmo_clr = (state_q == IDLE) && cmd_valid;
   // Ack has priority, so the counter only advances on cycles that neither complete nor expire.
   assign tmo_en  = (state_q == BUS) && !wb_ack && !tmo_expire;

   wb_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (tmo_clr),
      .en_i     (tmo_en),
      .expire_o (tmo_expire)
   );

   assign err_cnt_d = sat_inc(err_cnt_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rsp_valid_q   <= 1'b0;
         rsp_dat_q     <= '0;
         rsp_err_q     <= 1'b0;
         err_cnt_q     <= '0;
         wb_adr_q      <= '0;
         wb_dat_mosi_q <= '0;
         wb_we_q       <= 1'b0;
         wb_cyc_q      <= 1'b0;
         wb_stb_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  wb_we_q       <= cmd_we;
                  wb_adr_q      <= cmd_adr;
                  wb_dat_mosi_q <= cmd_dat;
                  wb_cyc_q      <= 1'b1;
                  wb_stb_q      <= 1'b1;
                  state_q       <= BUS;
               end
            end
            BUS: begin
               if (wb_ack || tmo_expire) begin
                  // Writes also return the slave's read data, i.e. the pre-write value.
                  rsp_dat_q   <= wb_ack ? wb_dat_miso : '0;
                  rsp_err_q   <= !wb_ack;
                  if (!wb_ack) begin
                     err_cnt_q <= err_cnt_d;
                  end
                  wb_cyc_q    <= 1'b0;
                  wb_stb_q    <= 1'b0;
                  wb_we_q     <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_dat     = rsp_dat_q;
   assign rsp_err     = rsp_err_q;
   assign err_cnt     = err_cnt_q;
   assign wb_adr      = wb_adr_q;
   assign wb_dat_mosi = wb_dat_mosi_q;
   assign wb_we       = wb_we_q;
   assign wb_cyc      = wb_cyc_q;
   assign wb_stb      = wb_stb_q;

endmodule

// File: tb/tb_wishbone_cmd_master.sv
// Scoreboard bench for wishbone_cmd_master against a 16x32 register-file slave model
// whose ack latency (in cycles of cyc high) is programmable; 0 means it never acks.
module tb_wishbone_cmd_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [3:0]  cmd_adr;
   logic [31:0] cmd_dat;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic [7:0]  err_cnt;
   logic [3:0]  wb_adr;
   logic [31:0] wb_dat_mosi;
   logic [31:0] wb_dat_miso;
   logic        wb_we;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_ack;

   always #5 clk = ~clk;

   wishbone_cmd_master #(
      .ADR_W   (4),
      .DAT_W   (32),
      .TIMEOUT (15)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_we      (cmd_we),
      .cmd_adr     (cmd_adr),
      .cmd_dat     (cmd_dat),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_dat     (rsp_dat),
      .rsp_err     (rsp_err),
      .err_cnt     (err_cnt),
      .wb_adr      (wb_adr),
      .wb_dat_mosi (wb_dat_mosi),
      .wb_dat_miso (wb_dat_miso),
      .wb_we       (wb_we),
      .wb_cyc      (wb_cyc),
      .wb_stb      (wb_stb),
      .wb_ack      (wb_ack)
   );

   // Slave model: registered ack raised on the ack_delay-th edge that sees cyc&stb.
   logic [31:0] mem [16];
   int          ack_delay = 1;
   int          slv_n = 0;
   logic        slv_ack = 1'b0;
   logic [31:0] slv_rdat = '0;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
   end

   always @(posedge clk) begin
      slv_ack <= 1'b0;
      if (wb_cyc && wb_stb && !slv_ack) begin
         slv_n <= slv_n + 1;
         if (slv_n + 1 == ack_delay) begin
            slv_ack  <= 1'b1;
            slv_rdat <= mem[wb_adr];
            if (wb_we) mem[wb_adr] <= wb_dat_mosi;
            slv_n    <= 0;
         end
      end else if (!wb_cyc) begin
         slv_n <= 0;
      end
   end

   assign wb_ack      = slv_ack;
   assign wb_dat_miso = slv_rdat;

   typedef struct {
      logic [31:0] dat;
      logic        err;
      logic [7:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   n_rsp = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a response is consumed on the edge after valid&ready is seen here.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rsp: got dat=%h err=%0b required no response", rsp_dat, rsp_err);
            end else begin
               e = exp_q.pop_front();
               $display("rsp %0d: dat=%h err=%0b err_cnt=%0d", n_rsp, rsp_dat, rsp_err, err_cnt);
               chk("rsp_dat", rsp_dat, e.dat);
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
               chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
            end
         end
      end
   end

   task automatic wait_ready();
      logic ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("cmd_ready_wait", 32'(ok), 32'd1);
   endtask

   task automatic do_cmd(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                         input int dly, input logic [31:0] edat, input logic eerr,
                         input int elen, input int ecnt);
      int n = 0;
      ack_delay = dly;
      wait_ready();
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_valid = 1'b1;
      exp_q.push_back('{dat: edat, err: eerr, cnt: 8'(ecnt)});
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("bus_we", 32'(wb_we), 32'(we));
      chk("bus_adr", 32'(wb_adr), 32'(adr));
      while (wb_cyc && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("cyc_len", n, elen);
      chk("rsp_latency", 32'(rsp_valid), 32'd1);
      wait_ready();
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = '0;
      cmd_dat   = '0;
      rsp_ready = 1'b1;
      #23;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_dat", rsp_dat, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_wb_cyc", 32'(wb_cyc), 32'd0);
      chk("rst_wb_stb", 32'(wb_stb), 32'd0);
      chk("rst_wb_we", 32'(wb_we), 32'd0);
      chk("rst_wb_adr", 32'(wb_adr), 32'd0);
      chk("rst_wb_mosi", wb_dat_mosi, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Write returns the pre-write contents, then read back the new value.
      do_cmd(1'b1, 4'd3, 32'hDEAD_BEEF, 1, 32'h1000_0003, 1'b0, 2, 0);
      chk("hold_wb_adr", 32'(wb_adr), 32'd3);
      chk("hold_wb_mosi", wb_dat_mosi, 32'hDEAD_BEEF);
      chk("idle_wb_we", 32'(wb_we), 32'd0);
      do_cmd(1'b0, 4'd3, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 2, 0);

      // No ack: full timeout.
      do_cmd(1'b0, 4'd5, 32'h0, 0, 32'h0, 1'b1, 15, 1);
      // Ack sampled on the expiring edge wins.
      do_cmd(1'b0, 4'd5, 32'h0, 14, 32'h1000_0005, 1'b0, 15, 1);
      // Ack one cycle too late: timeout, and the stray ack must not make a response.
      do_cmd(1'b0, 4'd6, 32'h0, 15, 32'h0, 1'b1, 15, 2);

      // Response backpressure with a second command already waiting.
      ack_delay = 1;
      wait_ready();
      rsp_ready = 1'b0;
      cmd_we    = 1'b1;
      cmd_adr   = 4'd7;
      cmd_dat   = 32'h1234_5678;
      cmd_valid = 1'b1;
      exp_q.push_back('{dat: 32'h1000_0007, err: 1'b0, cnt: 8'd2});
      @(posedge clk);
      #1 cmd_we = 1'b0;
      cmd_dat = 32'h0;
      exp_q.push_back('{dat: 32'h1234_5678, err: 1'b0, cnt: 8'd2});
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_dat", rsp_dat, 32'h1000_0007);
         chk("bp_rsp_err", 32'(rsp_err), 32'd0);
         chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("bp_wb_cyc", 32'(wb_cyc), 32'd0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_gap_cyc", 32'(wb_cyc), 32'd0);
      chk("bp_gap_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_cyc", 32'(wb_cyc), 32'd1);
      wait_ready();

      // Reset pulse mid-BUS: everything clears at once and the command is dropped.
      ack_delay = 0;
      cmd_we    = 1'b0;
      cmd_adr   = 4'd2;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rstmid_wb_cyc", 32'(wb_cyc), 32'd0);
      chk("rstmid_wb_stb", 32'(wb_stb), 32'd0);
      chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid_err_cnt", 32'(err_cnt), 32'd0);
      chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_cyc", 32'(wb_cyc), 32'd0);
      chk("post_rst_valid", 32'(rsp_valid), 32'd0);

      // Saturation of the timeout counter.
      for (int i = 1; i <= 260; i++) begin
         do_cmd(1'b0, 4'd1, 32'h0, 0, 32'h0, 1'b1, 15, (i > 255) ? 255 : i);
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1, "bench timeout");
   end

endmodule
